// File: rtl/mem_stage.sv
// mem_stage: RV32I memory-access pipeline stage.
//
// Registers the ALU stage's ex2mem packet and, for loads and stores, runs one
// transaction on a req/gnt/rvalid data-memory bus before it presents the
// writeback result. Non-memory instructions leave one cycle after capture.
//
// Ports
//   clk, rst          rising-edge clock; synchronous active-high reset
//   stall_i           downstream hold: blocks capture and keeps a finished result
//   ex2mem_i          ALU packet (pc, inst32, instValid, destReg, res)
//   storeData_i       rs2 value for stores, aligned with ex2mem_i
//   stall_o           stage busy; upstream must hold its inputs
//   dmem_*            data-memory request and response bus
//   wb_*              writeback result of the held instruction
//   misalign_o        held instruction is a misaligned load or store

package mem_stage_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst32;
    logic        instValid;
    logic [4:0]  destReg;
    logic [31:0] res;
  } ex2mem_pkt_t;

  typedef enum logic [1:0] {
    ST_DONE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  // funct3[1:0] encodes access size: 00 byte, 01 half, 10 word.
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      2'b00:   is_aligned = 1'b1;
      2'b01:   is_aligned = ~addr_lo[0];
      default: is_aligned = (addr_lo == 2'b00);
    endcase
  endfunction

endpackage

module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int XLEN = 32  // only 32 is supported
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  ex2mem_pkt_t     ex2mem_i,
  input  logic [XLEN-1:0] storeData_i,
  output logic            stall_o,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [3:0]      dmem_be_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  input  logic            dmem_gnt_i,
  input  logic            dmem_rvalid_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output logic            wb_valid_o,
  output logic [XLEN-1:0] wb_pc_o,
  output logic [XLEN-1:0] wb_inst_o,
  output logic [4:0]      wb_destReg_o,
  output logic [XLEN-1:0] wb_res_o,
  output logic            misalign_o
);

  ex2mem_pkt_t     pkt_q;
  logic [XLEN-1:0] sdata_q;
  logic [XLEN-1:0] load_res_q;
  state_e          state_q, state_d;

  // Decode of the incoming packet, used only to choose the state entered on capture.
  logic in_mem, in_issue, capture;
  assign in_mem   = (ex2mem_i.inst32[6:0] == OP_LOAD) || (ex2mem_i.inst32[6:0] == OP_STORE);
  assign in_issue = ex2mem_i.instValid && in_mem
                    && is_aligned(ex2mem_i.inst32[13:12], ex2mem_i.res[1:0]);
  assign capture  = !stall_i && (state_q == ST_DONE);

  // Decode of the held instruction.
  logic [2:0] funct3;
  logic [1:0] addr_lo;
  logic       q_load, q_store, q_misalign, issuing;
  assign funct3     = pkt_q.inst32[14:12];
  assign addr_lo    = pkt_q.res[1:0];
  assign q_load     = pkt_q.instValid && (pkt_q.inst32[6:0] == OP_LOAD);
  assign q_store    = pkt_q.instValid && (pkt_q.inst32[6:0] == OP_STORE);
  assign q_misalign = (q_load || q_store) && !is_aligned(funct3[1:0], addr_lo);
  assign issuing    = (state_q == ST_ISSUE);

  // Load data: move the addressed lane down to bit 0, then extend by funct3.
  logic [XLEN-1:0] rd_shift, load_ext;
  assign rd_shift = dmem_rdata_i >> {addr_lo, 3'b000};

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    load_ext = rd_shift;
    case (funct3)
      3'b000:  load_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  load_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  load_ext = {24'h0, rd_shift[7:0]};
      3'b101:  load_ext = {16'h0, rd_shift[15:0]};
      default: load_ext = rd_shift;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_DONE:  if (capture) state_d = in_issue ? ST_ISSUE : ST_DONE;
      ST_ISSUE: if (dmem_gnt_i) state_d = q_store ? ST_DONE : ST_RESP;
      ST_RESP:  if (dmem_rvalid_i) state_d = ST_DONE;
      default:  state_d = ST_DONE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: the datapath registers are reset along with the state so that every
    // output, including pc/inst/res, reads zero straight after reset.
    if (rst) begin
      pkt_q      <= '0;
      sdata_q    <= '0;
      load_res_q <= '0;
      state_q    <= ST_DONE;
    end else begin
      // NOTE: non-blocking assignments keep every register update on the same
      // edge independent of statement order.
      state_q <= state_d;
      if (capture) begin
        pkt_q   <= ex2mem_i;
        sdata_q <= storeData_i;
      end
      // rvalid only counts in RESP, so a response arriving after reset is dropped.
      if (state_q == ST_RESP && dmem_rvalid_i) begin
        load_res_q <= load_ext;
      end
    end
  end

  // Bus outputs come straight from held registers, so they stay stable until gnt.
  always_comb begin
    dmem_be_o    = 4'b0000;
    dmem_wdata_o = '0;
    if (issuing) begin
      case (funct3[1:0])
        2'b00: begin
          dmem_be_o    = 4'b0001 << addr_lo;
          dmem_wdata_o = {4{sdata_q[7:0]}};
        end
        2'b01: begin
          dmem_be_o    = addr_lo[1] ? 4'b1100 : 4'b0011;
          dmem_wdata_o = {2{sdata_q[15:0]}};
        end
        default: begin
          dmem_be_o    = 4'b1111;
          dmem_wdata_o = sdata_q;
        end
      endcase
    end
  end

  assign stall_o      = (state_q != ST_DONE);
  assign dmem_req_o   = issuing;
  assign dmem_we_o    = issuing && q_store;
  assign dmem_addr_o  = issuing ? {pkt_q.res[31:2], 2'b00} : '0;

  assign wb_valid_o   = (state_q == ST_DONE) && pkt_q.instValid;
  assign wb_pc_o      = pkt_q.pc;
  assign wb_inst_o    = pkt_q.inst32;
  assign wb_destReg_o = (wb_valid_o && !q_store && !q_misalign) ? pkt_q.destReg : 5'd0;
  // A misaligned load reports its address as the result for the later trap.
  assign wb_res_o     = (q_load && !q_misalign) ? load_res_q : pkt_q.res;
  assign misalign_o   = q_misalign;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed bench for mem_stage. Stimulus pushes the expected
// writeback of each instruction into a scoreboard queue; a monitor pops and
// compares whenever a new instruction shows up as valid on the writeback port.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  ex2mem_pkt_t ex2mem_i;
  logic [31:0] storeData_i;
  logic        stall_o;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        wb_valid_o;
  logic [31:0] wb_pc_o, wb_inst_o, wb_res_o;
  logic [4:0]  wb_destReg_o;
  logic        misalign_o;

  mem_stage dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .ex2mem_i(ex2mem_i),
    .storeData_i(storeData_i), .stall_o(stall_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .wb_valid_o(wb_valid_o), .wb_pc_o(wb_pc_o), .wb_inst_o(wb_inst_o),
    .wb_destReg_o(wb_destReg_o), .wb_res_o(wb_res_o), .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  dest;
    logic [31:0] res;
    logic        mis;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  localparam logic [31:0] I_ADD = 32'h002081B3;
  localparam logic [31:0] I_LB  = 32'h00008283;
  localparam logic [31:0] I_LH  = 32'h00009503;
  localparam logic [31:0] I_LW6 = 32'h0000A303;
  localparam logic [31:0] I_LW9 = 32'h0000A483;
  localparam logic [31:0] I_LHU = 32'h0000D403;
  localparam logic [31:0] I_SB  = 32'h00208023;
  localparam logic [31:0] I_SH  = 32'h00209023;
  localparam logic [31:0] I_SW  = 32'h0020A023;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  function automatic ex2mem_pkt_t mk(input logic [31:0] pc, input logic [31:0] inst,
                                     input logic [4:0] dest, input logic [31:0] res);
    ex2mem_pkt_t p;
    p.pc = pc; p.inst32 = inst; p.instValid = 1'b1; p.destReg = dest; p.res = res;
    return p;
  endfunction

  function automatic exp_t ex(input logic [31:0] pc, input logic [4:0] dest,
                              input logic [31:0] res, input logic mis);
    exp_t e;
    e.pc = pc; e.dest = dest; e.res = res; e.mis = mis;
    return e;
  endfunction

  // Monitor: one comparison set per instruction, keyed on a new pc at writeback.
  logic [31:0] last_pc = 32'hFFFF_FFFF;
  always @(negedge clk) begin
    if (wb_valid_o && wb_pc_o !== last_pc) begin
      last_pc = wb_pc_o;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_wb: got pc 0x%08h want none", wb_pc_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("wb_pc", wb_pc_o, e.pc);
        check("wb_destReg", {27'd0, wb_destReg_o}, {27'd0, e.dest});
        check("wb_res", wb_res_o, e.res);
        check("misalign", {31'd0, misalign_o}, {31'd0, e.mis});
      end
    end
  end

  // Non-memory or misaligned instruction: done one cycle after capture, no request.
  task automatic run_alu(input ex2mem_pkt_t p, input exp_t e);
    sb.push_back(e);
    ex2mem_i = p;
    @(posedge clk); #1;
    ex2mem_i = '0;
    @(negedge clk);
    check("alu_stall", {31'd0, stall_o}, 32'd0);
    check("alu_req", {31'd0, dmem_req_o}, 32'd0);
    check("alu_valid", {31'd0, wb_valid_o}, 32'd1);
  endtask

  // Aligned access: checks the bus every ISSUE cycle and the stall every busy cycle.
  task automatic run_mem(input ex2mem_pkt_t p, input logic [31:0] sd, input exp_t e,
                         input int gnt_wait, input int rv_wait, input logic [31:0] rdata,
                         input logic [31:0] exp_addr, input logic [3:0] exp_be,
                         input logic [31:0] exp_wdata, input logic store);
    sb.push_back(e);
    ex2mem_i = p;
    storeData_i = sd;
    @(posedge clk); #1;
    ex2mem_i = '0;
    storeData_i = 32'hDEAD_0000;  // upstream changes must not reach the bus
    for (int i = 0; i <= gnt_wait; i++) begin
      @(negedge clk);
      check("issue_stall", {31'd0, stall_o}, 32'd1);
      check("issue_req", {31'd0, dmem_req_o}, 32'd1);
      check("issue_we", {31'd0, dmem_we_o}, {31'd0, store});
      check("issue_addr", dmem_addr_o, exp_addr);
      check("issue_be", {28'd0, dmem_be_o}, {28'd0, exp_be});
      if (store) check("issue_wdata", dmem_wdata_o, exp_wdata);
      if (i == gnt_wait) dmem_gnt_i = 1'b1;
      @(posedge clk); #1;
      dmem_gnt_i = 1'b0;
    end
    if (!store) begin
      for (int j = 0; j <= rv_wait; j++) begin
        @(negedge clk);
        check("resp_stall", {31'd0, stall_o}, 32'd1);
        check("resp_req", {31'd0, dmem_req_o}, 32'd0);
        if (j == rv_wait) begin
          dmem_rvalid_i = 1'b1;
          dmem_rdata_i  = rdata;
        end
        @(posedge clk); #1;
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = 32'h0;
      end
    end
    @(negedge clk);
    check("done_stall", {31'd0, stall_o}, 32'd0);
    check("done_req", {31'd0, dmem_req_o}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; stall_i = 1'b0; ex2mem_i = '0; storeData_i = '0;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_valid", {31'd0, wb_valid_o}, 32'd0);
    check("rst_stall", {31'd0, stall_o}, 32'd0);
    check("rst_req", {31'd0, dmem_req_o}, 32'd0);
    check("rst_res", wb_res_o, 32'd0);
    check("rst_dest", {27'd0, wb_destReg_o}, 32'd0);
    @(posedge clk); #1;

    // ADD: one cycle, result passed through.
    run_alu(mk(32'h100, I_ADD, 5'd3, 32'h5), ex(32'h100, 5'd3, 32'h5, 1'b0));

    // LB at 0x1003, gnt at once, rvalid next cycle: lane 3 = 0x80, sign-extended.
    run_mem(mk(32'h200, I_LB, 5'd5, 32'h1003), 32'h0, ex(32'h200, 5'd5, 32'hFFFF_FF80, 1'b0),
            0, 0, 32'h8012_3456, 32'h1000, 4'b1000, 32'h0, 1'b0);

    // SH at 0x2002, gnt after 3 wait cycles: bus stable for 4 cycles, no register write.
    run_mem(mk(32'h300, I_SH, 5'd7, 32'h2002), 32'h1234_ABCD, ex(32'h300, 5'd0, 32'h2002, 1'b0),
            3, 0, 32'h0, 32'h2000, 4'b1100, 32'hABCD_ABCD, 1'b1);

    // Misaligned LW: no request, trap flagged, no register write.
    run_alu(mk(32'h400, I_LW6, 5'd6, 32'h3001), ex(32'h400, 5'd0, 32'h3001, 1'b1));

    // LHU at 0x4002 finishing under a 5-cycle stall_i; the following ADD waits.
    sb.push_back(ex(32'h500, 5'd8, 32'h0000_BEEF, 1'b0));
    ex2mem_i = mk(32'h500, I_LHU, 5'd8, 32'h4002);
    @(posedge clk); #1;
    stall_i = 1'b1;
    dmem_gnt_i = 1'b1;
    sb.push_back(ex(32'h600, 5'd4, 32'h77, 1'b0));
    ex2mem_i = mk(32'h600, I_ADD, 5'd4, 32'h77);
    @(negedge clk);
    check("lhu_be", {28'd0, dmem_be_o}, 32'hC);
    @(posedge clk); #1;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hBEEF_0000;
    @(posedge clk); #1;
    dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("hold_stall", {31'd0, stall_o}, 32'd0);
      check("hold_req", {31'd0, dmem_req_o}, 32'd0);
      check("hold_pc", wb_pc_o, 32'h500);
      check("hold_res", wb_res_o, 32'h0000_BEEF);
      @(posedge clk); #1;
    end
    stall_i = 1'b0;
    @(posedge clk); #1;
    ex2mem_i = '0;
    @(negedge clk);
    check("release_pc", wb_pc_o, 32'h600);
    @(posedge clk); #1;

    // SB at 0x9001, one gnt wait cycle.
    run_mem(mk(32'h800, I_SB, 5'd1, 32'h9001), 32'h1122_3344, ex(32'h800, 5'd0, 32'h9001, 1'b0),
            1, 0, 32'h0, 32'h9000, 4'b0010, 32'h4444_4444, 1'b1);
    // LH at 0xA000, rvalid two cycles late: lane 0 = 0xF00D, sign-extended.
    run_mem(mk(32'h900, I_LH, 5'd10, 32'hA000), 32'h0, ex(32'h900, 5'd10, 32'hFFFF_F00D, 1'b0),
            0, 2, 32'h1234_F00D, 32'hA000, 4'b0011, 32'h0, 1'b0);
    // SW at 0xB004.
    run_mem(mk(32'hA00, I_SW, 5'd2, 32'hB004), 32'hCAFE_F00D, ex(32'hA00, 5'd0, 32'hB004, 1'b0),
            0, 0, 32'h0, 32'hB004, 4'b1111, 32'hCAFE_F00D, 1'b1);
    // Misaligned SH.
    run_alu(mk(32'hB00, I_SH, 5'd2, 32'hC001), ex(32'hB00, 5'd0, 32'hC001, 1'b1));

    // Reset while in RESP; the late rvalid must be ignored.
    ex2mem_i = mk(32'h700, I_LW9, 5'd9, 32'h7000);
    @(posedge clk); #1;
    ex2mem_i = '0;
    dmem_gnt_i = 1'b1;
    @(posedge clk); #1;
    dmem_gnt_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("resp_busy", {31'd0, stall_o}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hDEAD_BEEF;
    @(negedge clk);
    check("mid_rst_req", {31'd0, dmem_req_o}, 32'd0);
    check("mid_rst_valid", {31'd0, wb_valid_o}, 32'd0);
    check("mid_rst_stall", {31'd0, stall_o}, 32'd0);
    @(posedge clk); #1;
    dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;
    @(negedge clk);
    check("late_rv_valid", {31'd0, wb_valid_o}, 32'd0);
    check("late_rv_res", wb_res_o, 32'd0);
    check("late_rv_stall", {31'd0, stall_o}, 32'd0);

    repeat (2) @(posedge clk);
    check("sb_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
